cruise_cmd_arbiter: RTL and testbench
=====================================

Name: cruise_cmd_arbiter

Overview:
- Front-end sequencer that sits between the raw driver controls and the cruise controller.
- Converts button levels into single-cycle command pulses:
  - edge detection;
  - accel/coast auto-repeat on hold;
  - fixed-priority arbitration, one command per cycle;
  - post-brake/cancel lockout.
- Outputs connect directly to the cruise controller's set/accel/coast/cancel/resume/brake inputs.
- Cruise status (cruisecontrol) is fed back to gate commands that are meaningless in the current mode.

Parameters:
- REPEAT_DLY, 8: cycles accel/coast must remain held after the first pulse before auto-repeat starts (1..255).
- REPEAT_PER, 4: cycles between auto-repeat pulses while held (1..255).
- LOCKOUT, 3: cycles after a brake or cancel pulse during which set/resume/accel/coast are suppressed (1..255).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high.
- btn_set  input  1  raw set button level.
- btn_accel  input  1  raw accel button level.
- btn_coast  input  1  raw coast button level.
- btn_cancel  input  1  raw cancel button level.
- btn_resume  input  1  raw resume button level.
- pedal_brake  input  1  brake pedal level.
- cruisecontrol  input  1  status from cruise controller, 1 = auto mode.
- set  output  1  one-cycle set command.
- accel  output  1  one-cycle accel command.
- coast  output  1  one-cycle coast command.
- cancel  output  1  one-cycle cancel command.
- resume  output  1  one-cycle resume command.
- brake  output  1  registered brake level.
- conflict  output  1  high while accel and coast are held together.

Behaviour:
- Reset:
  - all outputs 0;
  - previous-level registers 0;
  - FSM = IDLE;
  - counters 0.
  - Reset asserted mid-repeat or mid-lockout aborts immediately; the next cycle behaves as from power-up.
  - A button already held when reset deasserts counts as a rising edge on the first post-reset cycle.
- Brake:
  - brake <= pedal_brake every cycle, a level, not a pulse.
  - Rising edge of pedal_brake enters LOCKOUT.
  - While pedal_brake is high, set/accel/coast/resume/cancel outputs are forced 0.
- Edge detection:
  - set, cancel and resume requests fire on a rising edge (btn=1, prev=0) only.
  - Latency: output pulse in the cycle after the edge is sampled.
- Mode gating:
  - accel/coast are issued only if cruisecontrol=1.
  - resume is issued only if cruisecontrol=0.
  - set is allowed in either mode.
  - cancel is issued only if cruisecontrol=1.
  - A gated request is dropped, not queued.
- Priority, at most one pulse per cycle: brake > cancel > set > resume > accel > coast.
  - Losing edge requests are dropped.
  - A losing accel/coast hold keeps its FSM timing, but a suppressed pulse is not re-issued.
- accel/coast FSM, states IDLE, HOLD_WAIT, REPEAT, LOCKOUT:
  - IDLE:
    - rising edge of exactly one of accel/coast: pulse that command, cnt <= REPEAT_DLY-1, go to HOLD_WAIT, latch dir.
  - HOLD_WAIT:
    - if the latched button is released, or the opposite button is pressed: go to IDLE, no pulse;
    - else if cnt==0: pulse dir, cnt <= REPEAT_PER-1, go to REPEAT;
    - else cnt--.
  - REPEAT:
    - same release/opposite rule;
    - cnt==0: pulse, reload REPEAT_PER-1.
    - Unlimited repeats; the cruise controller owns speedset wrap.
  - LOCKOUT:
    - entered from any state on a cancel pulse or brake rising edge;
    - cnt <= LOCKOUT-1;
    - suppress set/resume/accel/coast;
    - exit to IDLE when cnt==0 and pedal_brake=0;
    - held while pedal_brake=1.
    - Edges occurring during LOCKOUT are discarded; the button must be re-pressed after exit.
- Conflict:
  - btn_accel && btn_coast both high → conflict=1 (registered, 1-cycle latency).
  - FSM forced to IDLE; no accel/coast pulses until both are released and one is pressed again.
- Counters: 8-bit, down-counting, never wrap; they are reloaded before reaching 0 minus 1.

Decomposition:
- Shared package cruise_pkg:
  - 2-bit FSM state encoding constants ARB_IDLE, ARB_HOLD, ARB_REPEAT, ARB_LOCK;
  - command priority ordering;
  - width constant SPD_W=8, reused by the cruise controller.
- One natural sub-module, btn_edge: a parameterised-width prev-level register plus rising-edge vector, instantiated once for the 6 inputs.

Test Plan:
- Reset, then btn_set rises at cycle 5 → set=1 at cycle 6 only. Holding btn_set for 20 cycles yields no further pulses.
- cruisecontrol=1, btn_accel held 20 cycles from cycle 10, defaults → accel pulses at cycles 11, 19, 23, 27; none after release.
- cruisecontrol=1, btn_cancel and btn_set rise in the same cycle → cancel only.
  - btn_set re-pressed 1 cycle later → dropped (LOCKOUT).
  - btn_set re-pressed 4 cycles after cancel → set pulse.
- Mid-REPEAT, pedal_brake rises → brake=1 next cycle, accel pulses stop.
  - Brake held 10 cycles, then released → FSM returns to IDLE 1 cycle later; accel still held → no pulse until re-press.
- btn_accel and btn_coast high together → conflict=1 next cycle, no pulses.
  - Release coast → still no pulse; release and re-press accel → accel pulse.
- Reset asserted during HOLD_WAIT with accel held → all outputs 0.
  - Reset released with accel held → accel pulse 1 cycle after release.

Source files
------------

// File: rtl/cruise_pkg.sv
// Shared types and constants for the cruise command front end and the cruise controller.
package cruise_pkg;

  localparam int unsigned SPD_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD   = 2'd1,
    ARB_REPEAT = 2'd2,
    ARB_LOCK   = 2'd3
  } arb_state_e;

  typedef enum logic {
    DIR_ACCEL = 1'b0,
    DIR_COAST = 1'b1
  } dir_e;

  // Raw control levels as seen by the edge detector.
  typedef struct packed {
    logic brake;
    logic cancel;
    logic set;
    logic resume;
    logic accel;
    logic coast;
  } btn_vec_t;

  localparam int unsigned BTN_W = $bits(btn_vec_t);

  // Command pulses, most significant field has the highest priority.
  typedef struct packed {
    logic cancel;
    logic set;
    logic resume;
    logic accel;
    logic coast;
  } cmd_t;

  function automatic cmd_t arb_pick(input cmd_t req);
    cmd_t g;
    g = '0;
    if (req.cancel)      g.cancel = 1'b1;
    else if (req.set)    g.set    = 1'b1;
    else if (req.resume) g.resume = 1'b1;
    else if (req.accel)  g.accel  = 1'b1;
    else if (req.coast)  g.coast  = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/cruise_cmd_arbiter_if.sv
// Driver-control inputs and cruise-controller command outputs of the arbiter.
interface cruise_cmd_arbiter_if;

  logic btn_set;
  logic btn_accel;
  logic btn_coast;
  logic btn_cancel;
  logic btn_resume;
  logic pedal_brake;
  logic cruisecontrol;

  logic set;
  logic accel;
  logic coast;
  logic cancel;
  logic resume;
  logic brake;
  logic conflict;

  modport master (
    output btn_set, btn_accel, btn_coast, btn_cancel, btn_resume, pedal_brake, cruisecontrol,
    input  set, accel, coast, cancel, resume, brake, conflict
  );

  modport slave (
    input  btn_set, btn_accel, btn_coast, btn_cancel, btn_resume, pedal_brake, cruisecontrol,
    output set, accel, coast, cancel, resume, brake, conflict
  );

endinterface

// File: rtl/btn_edge.sv
// Previous-level register and rising-edge vector for a bundle of raw levels.
module btn_edge #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] prev;

  // Clearing prev on reset makes a level held across reset read as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= din;
  end

  assign rise_c = din & ~prev;

endmodule

// File: rtl/cruise_cmd_arbiter.sv
// Turns driver button levels into prioritised single-cycle commands for the cruise controller,
// with accel/coast auto-repeat and a lockout window after brake or cancel.
module cruise_cmd_arbiter
  import cruise_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = 8,
  parameter int unsigned REPEAT_PER = 4,
  parameter int unsigned LOCKOUT    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  cruise_cmd_arbiter_if.slave  bus
);

  btn_vec_t         rise;
  arb_state_e       state, state_n;
  dir_e             dir, dir_n;
  logic [SPD_W-1:0] cnt, cnt_n;
  cmd_t             req, cmd_d;
  logic             dir_btn, opp_btn, hold_break, hold_fire, suppress, lock_entry;

  btn_edge #(.W(BTN_W)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .din    ({bus.pedal_brake, bus.btn_cancel, bus.btn_set,
              bus.btn_resume, bus.btn_accel, bus.btn_coast}),
    .rise_c (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      cnt   <= '0;
      dir   <= DIR_ACCEL;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir   <= dir_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir;
    req     = '0;
    cmd_d   = '0;

    dir_btn    = (dir == DIR_COAST) ? bus.btn_coast : bus.btn_accel;
    opp_btn    = (dir == DIR_COAST) ? bus.btn_accel : bus.btn_coast;
    hold_break = !dir_btn || opp_btn;
    hold_fire  = ((state == ARB_HOLD) || (state == ARB_REPEAT)) && !hold_break && (cnt == '0);
    suppress   = (state == ARB_LOCK) || bus.pedal_brake;

    // Mode gating and lockout suppression are applied before arbitration, so gated requests vanish.
    req.cancel = rise.cancel && bus.cruisecontrol;
    req.set    = rise.set && !suppress;
    req.resume = rise.resume && !bus.cruisecontrol && !suppress;
    req.accel  = bus.cruisecontrol && !suppress &&
                 (((state == ARB_IDLE) && rise.accel && !bus.btn_coast) ||
                  (hold_fire && (dir == DIR_ACCEL)));
    req.coast  = bus.cruisecontrol && !suppress &&
                 (((state == ARB_IDLE) && rise.coast && !bus.btn_accel) ||
                  (hold_fire && (dir == DIR_COAST)));

    if (!bus.pedal_brake) cmd_d = arb_pick(req);

    lock_entry = rise.brake || cmd_d.cancel;

    // Hold/repeat timing runs whether or not its pulse won arbitration.
    if (lock_entry) begin
      state_n = ARB_LOCK;
      cnt_n   = SPD_W'(LOCKOUT - 1);
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (cmd_d.accel || cmd_d.coast) begin
            state_n = ARB_HOLD;
            cnt_n   = SPD_W'(REPEAT_DLY - 1);
            dir_n   = cmd_d.coast ? DIR_COAST : DIR_ACCEL;
          end
        end
        ARB_HOLD, ARB_REPEAT: begin
          if (hold_break) begin
            state_n = ARB_IDLE;
          end else if (cnt == '0) begin
            state_n = ARB_REPEAT;
            cnt_n   = SPD_W'(REPEAT_PER - 1);
          end else begin
            cnt_n = cnt - SPD_W'(1);
          end
        end
        ARB_LOCK: begin
          if (cnt != '0)             cnt_n   = cnt - SPD_W'(1);
          else if (!bus.pedal_brake) state_n = ARB_IDLE;
        end
        default: state_n = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.set      <= 1'b0;
      bus.accel    <= 1'b0;
      bus.coast    <= 1'b0;
      bus.cancel   <= 1'b0;
      bus.resume   <= 1'b0;
      bus.brake    <= 1'b0;
      bus.conflict <= 1'b0;
    end else begin
      bus.set      <= cmd_d.set;
      bus.accel    <= cmd_d.accel;
      bus.coast    <= cmd_d.coast;
      bus.cancel   <= cmd_d.cancel;
      bus.resume   <= cmd_d.resume;
      bus.brake    <= bus.pedal_brake;
      bus.conflict <= bus.btn_accel && bus.btn_coast;
    end
  end

endmodule

// File: tb/tb_cruise_cmd_arbiter.sv
// Bench for cruise_cmd_arbiter: timestamp-based reference model checked every cycle,
// plus literal pulse-cycle expectations for the directed scenarios.
module tb_cruise_cmd_arbiter;

  localparam int unsigned REPEAT_DLY = 8;
  localparam int unsigned REPEAT_PER = 4;
  localparam int unsigned LOCKOUT    = 3;

  localparam int B_SET = 6, B_ACC = 5, B_CST = 4, B_CAN = 3, B_RES = 2, B_BRK = 1, B_CNF = 0;
  localparam int MAXC = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cruise_cmd_arbiter_if bus();

  cruise_cmd_arbiter #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER),
    .LOCKOUT    (LOCKOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit exp_valid = 1'b0;
  logic [6:0] exp_q;
  logic [6:0] hist [MAXC];

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, want);
  endtask

  function automatic logic [6:0] obs();
    return {bus.set, bus.accel, bus.coast, bus.cancel, bus.resume, bus.brake, bus.conflict};
  endfunction

  // Reference model: lockout and auto-repeat expressed as timestamps and ages, not counters.
  bit m_pa, m_pc, m_ps, m_pcan, m_pres, m_pp;
  bit lock_on = 1'b0;
  int lock_first = 0;
  bit trk = 1'b0;
  bit trk_cst = 1'b0;
  int trk_t0 = 0;

  always @(posedge clk) begin : model
    bit a, c, p, cr, ra, rc, rs, rcan, rres, rp;
    bit sup, was_trk, hold_fire, can_ok, set_ok, res_ok, acc_ok, cst_ok;
    int age;
    logic [6:0] nx;
    a  = bus.btn_accel;
    c  = bus.btn_coast;
    p  = bus.pedal_brake;
    cr = bus.cruisecontrol;
    nx = '0;
    if (reset) begin
      {m_pa, m_pc, m_ps, m_pcan, m_pres, m_pp} = '0;
      lock_on = 1'b0;
      trk     = 1'b0;
    end else begin
      ra   = a && !m_pa;
      rc   = c && !m_pc;
      rs   = bus.btn_set && !m_ps;
      rcan = bus.btn_cancel && !m_pcan;
      rres = bus.btn_resume && !m_pres;
      rp   = p && !m_pp;
      sup  = lock_on || p;
      was_trk   = trk;
      hold_fire = 1'b0;
      if (trk) begin
        if (trk_cst ? (!c || a) : (!a || c)) begin
          trk = 1'b0;
        end else begin
          age = cyc - trk_t0;
          if (age >= int'(REPEAT_DLY) && ((age - int'(REPEAT_DLY)) % int'(REPEAT_PER)) == 0)
            hold_fire = 1'b1;
        end
      end
      can_ok = rcan && cr && !p;
      set_ok = rs && !sup;
      res_ok = rres && !cr && !sup;
      acc_ok = cr && !sup && ((!was_trk && ra && !c) || (hold_fire && !trk_cst));
      cst_ok = cr && !sup && ((!was_trk && rc && !a) || (hold_fire && trk_cst));
      nx[B_BRK] = p;
      nx[B_CNF] = a && c;
      if (!p) begin
        if (can_ok)      nx[B_CAN] = 1'b1;
        else if (set_ok) nx[B_SET] = 1'b1;
        else if (res_ok) nx[B_RES] = 1'b1;
        else if (acc_ok) nx[B_ACC] = 1'b1;
        else if (cst_ok) nx[B_CST] = 1'b1;
      end
      if (rp || nx[B_CAN]) begin
        lock_on    = 1'b1;
        lock_first = cyc + 1;
        trk        = 1'b0;
      end else if (lock_on) begin
        if (cyc >= lock_first + int'(LOCKOUT) - 1 && !p) lock_on = 1'b0;
      end else if (!was_trk && (nx[B_ACC] || nx[B_CST])) begin
        trk     = 1'b1;
        trk_cst = nx[B_CST];
        trk_t0  = cyc;
      end
      m_pa = a; m_pc = c; m_ps = bus.btn_set; m_pcan = bus.btn_cancel;
      m_pres = bus.btn_resume; m_pp = p;
    end
    exp_q     = nx;
    exp_valid = 1'b1;
    cyc++;
  end

  always @(negedge clk) begin
    if (exp_valid) check("cycle_outputs", obs(), exp_q);
    if (cyc < MAXC) hist[cyc] = obs();
  end

  function automatic int count_bit(input int b, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (hist[k][b] === 1'b1) n++;
    return n;
  endfunction

  task automatic pin_bit(input string name, input int at, input int b, input logic want);
    check(name, 7'(hist[at][b]), 7'(want));
  endtask

  task automatic pin_count(input string name, input int b, input int lo, input int hi, input int want);
    check(name, 7'(count_bit(b, lo, hi)), 7'(want));
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) next();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.btn_set = 1'b0; bus.btn_accel = 1'b0; bus.btn_coast = 1'b0; bus.btn_cancel = 1'b0;
    bus.btn_resume = 1'b0; bus.pedal_brake = 1'b0; bus.cruisecontrol = 1'b0;
    reset = 1'b1;
    wait_to(3); reset = 1'b0;
    wait_to(4);
    check("reset_outputs", hist[2], 7'b0);

    // set edge fires once even when held
    wait_to(5);  bus.btn_set = 1'b1;
    wait_to(25); bus.btn_set = 1'b0;
    wait_to(27);
    pin_bit("set_before_edge", 5, B_SET, 1'b0);
    pin_bit("set_pulse", 6, B_SET, 1'b1);
    pin_count("set_held_no_repeat", B_SET, 7, 26, 0);

    // accel auto-repeat: 31, 39, 43, 47
    wait_to(28); bus.cruisecontrol = 1'b1;
    wait_to(30); bus.btn_accel = 1'b1;
    wait_to(50); bus.btn_accel = 1'b0;
    wait_to(56);
    pin_bit("accel_first", 31, B_ACC, 1'b1);
    pin_bit("accel_repeat_start", 39, B_ACC, 1'b1);
    pin_bit("accel_repeat_2", 43, B_ACC, 1'b1);
    pin_bit("accel_repeat_3", 47, B_ACC, 1'b1);
    pin_count("accel_pulse_total", B_ACC, 30, 55, 4);

    // cancel beats set, then lockout drops a quick re-press
    wait_to(62); bus.btn_cancel = 1'b1; bus.btn_set = 1'b1;
    wait_to(63); bus.btn_cancel = 1'b0; bus.btn_set = 1'b0;
    wait_to(64); bus.btn_set = 1'b1;
    wait_to(65); bus.btn_set = 1'b0;
    wait_to(67); bus.btn_set = 1'b1;
    wait_to(69); bus.btn_set = 1'b0;
    wait_to(70);
    pin_bit("cancel_wins", 63, B_CAN, 1'b1);
    pin_bit("set_loses_to_cancel", 63, B_SET, 1'b0);
    pin_count("set_in_lockout", B_SET, 64, 67, 0);
    pin_bit("set_after_lockout", 68, B_SET, 1'b1);

    // brake mid-repeat, held 10 cycles, accel still held afterwards
    wait_to(72);  bus.btn_accel = 1'b1;
    wait_to(87);  bus.pedal_brake = 1'b1;
    wait_to(97);  bus.pedal_brake = 1'b0;
    wait_to(100); bus.btn_accel = 1'b0;
    wait_to(102); bus.btn_accel = 1'b1;
    wait_to(104); bus.btn_accel = 1'b0;
    wait_to(105);
    pin_bit("accel_repeat_pre_brake", 85, B_ACC, 1'b1);
    pin_bit("brake_pre", 87, B_BRK, 1'b0);
    pin_bit("brake_level", 88, B_BRK, 1'b1);
    pin_bit("brake_last", 97, B_BRK, 1'b1);
    pin_bit("brake_released", 98, B_BRK, 1'b0);
    pin_count("accel_after_brake", B_ACC, 86, 102, 0);
    pin_bit("accel_repress", 103, B_ACC, 1'b1);

    // accel and coast together
    wait_to(106); bus.btn_accel = 1'b1; bus.btn_coast = 1'b1;
    wait_to(110); bus.btn_coast = 1'b0;
    wait_to(112); bus.btn_accel = 1'b0;
    wait_to(114); bus.btn_accel = 1'b1;
    wait_to(116); bus.btn_accel = 1'b0;
    wait_to(117);
    pin_bit("conflict_pre", 106, B_CNF, 1'b0);
    pin_bit("conflict_set", 107, B_CNF, 1'b1);
    pin_bit("conflict_held", 110, B_CNF, 1'b1);
    pin_bit("conflict_clear", 111, B_CNF, 1'b0);
    pin_count("accel_during_conflict", B_ACC, 107, 114, 0);
    pin_count("coast_during_conflict", B_CST, 107, 116, 0);
    pin_bit("accel_after_conflict", 115, B_ACC, 1'b1);

    // mode gating with cruise off
    wait_to(118); bus.cruisecontrol = 1'b0;
    wait_to(120); bus.btn_resume = 1'b1;
    wait_to(122); bus.btn_resume = 1'b0; bus.btn_accel = 1'b1;
    wait_to(124); bus.btn_cancel = 1'b1;
    wait_to(125); bus.btn_set = 1'b1;
    wait_to(127); bus.btn_set = 1'b0; bus.btn_cancel = 1'b0; bus.btn_accel = 1'b0;
    wait_to(128);
    pin_bit("resume_manual", 121, B_RES, 1'b1);
    pin_count("accel_gated", B_ACC, 122, 127, 0);
    pin_count("cancel_gated", B_CAN, 124, 127, 0);
    pin_bit("set_no_lockout", 126, B_SET, 1'b1);

    // reset during HOLD_WAIT with accel held
    wait_to(129); bus.cruisecontrol = 1'b1;
    wait_to(130); bus.btn_accel = 1'b1;
    wait_to(134); reset = 1'b1;
    wait_to(137); reset = 1'b0;
    wait_to(148); bus.btn_accel = 1'b0;
    wait_to(149);
    pin_bit("accel_before_reset", 131, B_ACC, 1'b1);
    check("reset_mid_hold", hist[135], 7'b0);
    check("reset_last_cycle", hist[137], 7'b0);
    pin_bit("accel_after_reset", 138, B_ACC, 1'b1);
    pin_count("accel_hold_wait", B_ACC, 139, 145, 0);
    pin_bit("accel_repeat_after_reset", 146, B_ACC, 1'b1);

    // coast repeat broken by opposite button
    wait_to(150); bus.btn_coast = 1'b1;
    wait_to(160); bus.btn_accel = 1'b1;
    wait_to(162); bus.btn_accel = 1'b0;
    wait_to(164); bus.btn_coast = 1'b0;
    wait_to(168);
    pin_bit("coast_first", 151, B_CST, 1'b1);
    pin_bit("coast_repeat", 159, B_CST, 1'b1);
    pin_count("coast_after_opposite", B_CST, 160, 167, 0);
    pin_count("accel_opposite_press", B_ACC, 160, 167, 0);
    pin_bit("conflict_opposite", 161, B_CNF, 1'b1);

    wait_to(170);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
